riscv_pipe_skid_stage: RTL and testbench

- Parametrised successor to the fixed EX-style pipeline register.
- A chain of STAGES elastic register slots with a valid/ready handshake. Each slot is a 2-entry skid buffer, so backpressure never creates a combinational ready path and full throughput is kept.
- Supports synchronous pipeline flush and reports occupancy.
- Used between EXn/MEM stages wherever a downstream stall (for example a D-cache miss) must propagate upstream without timing-critical ready chains at 2 GHz.

---
 rtl/riscv_pipe_pkg.sv | 30 +++
 rtl/riscv_skid_slot.sv | 76 +++++++
 rtl/riscv_pipe_skid_stage.sv | 77 +++++++
 tb/tb_riscv_pipe_skid_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared types for the EX/MEM elastic pipeline registers.
package riscv_pipe_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // Instruction metadata that travels alongside the generic payload
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic [4:0]      rd_addr;
    } pipe_beat_t;

    // Slot state encoded as {skid_v, main_v}; 2'b10 is the illegal combination
    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'b00,
        SLOT_ONE   = 2'b01,
        SLOT_FULL  = 2'b11
    } slot_state_t;

    // Number of beats held by a slot in a given state
    function automatic logic [1:0] slot_count(input slot_state_t s);
        case (s)
            SLOT_ONE:  slot_count = 2'd1;
            SLOT_FULL: slot_count = 2'd2;
            default:   slot_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_skid_slot.sv
// One 2-entry skid slot: a main register that drives the output and a skid
// register that absorbs the beat arriving in the cycle the downstream stalls.
// in_ready comes straight from a flop, so no ready chain crosses the slot.
module riscv_skid_slot
    import riscv_pipe_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  pipe_beat_t        in_beat,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output pipe_beat_t        out_beat,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic              main_v, skid_v;
    pipe_beat_t        main_beat, skid_beat;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              push, pop;
    slot_state_t       state;

    // flush wins over push so a beat offered during flush is dropped
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = main_v & out_ready;
    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign out_beat  = main_beat;
    assign out_data  = main_data;
    assign state     = slot_state_t'({skid_v, main_v});
    assign count     = slot_count(state);

    // Control state: EMPTY -> ONE -> FULL and back; flush clears everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (!main_v) begin
            main_v <= push;
        end else if (!skid_v) begin
            if (push && !pop) skid_v <= 1'b1;
            if (!push && pop) main_v <= 1'b0;
        end else if (pop) begin
            skid_v <= 1'b0;
        end
    end

    // Payload registers carry no reset; skid always refills main before newer beats
    always_ff @(posedge clk) begin
        if (push && (!main_v || pop)) begin
            main_beat <= in_beat;
            main_data <= in_data;
        end else if (skid_v && pop) begin
            main_beat <= skid_beat;
            main_data <= skid_data;
        end
        if (push && main_v && !pop) begin
            skid_beat <= in_beat;
            skid_data <= in_data;
        end
    end

    // A skid entry without a main entry would break FIFO order
    a_no_orphan_skid: assert property (@(posedge clk) disable iff (rst)
        !(skid_v && !main_v));

endmodule

// File: rtl/riscv_pipe_skid_stage.sv
// Chain of STAGES skid slots between EXn/MEM: STAGES-cycle latency, full
// throughput, registered ready, synchronous flush and occupancy count.
module riscv_pipe_skid_stage
    import riscv_pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int STAGES = 1,
    parameter int CNT_W  = $clog2(2*STAGES+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [ILEN-1:0]   in_inst,
    input  logic [4:0]        in_rd_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [ILEN-1:0]   out_inst,
    output logic [4:0]        out_rd_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  occupancy
);

    // Link g feeds slot g; link STAGES is the stage output
    pipe_beat_t        beat_l [STAGES+1];
    logic [DATA_W-1:0] data_l [STAGES+1];
    logic              vld_l  [STAGES+1];
    logic              rdy_l  [STAGES+1];
    logic [1:0]        cnt    [STAGES];
    logic              rdy_en;

    // Holds in_ready low through reset and the release cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_en <= 1'b0;
        else     rdy_en <= 1'b1;
    end

    assign beat_l[0]     = '{pc: in_pc, inst: in_inst, rd_addr: in_rd_addr};
    assign data_l[0]     = in_data;
    assign vld_l[0]      = in_valid & rdy_en;
    assign in_ready      = rdy_en & rdy_l[0];
    assign rdy_l[STAGES] = out_ready;

    assign out_valid   = vld_l[STAGES];
    assign out_pc      = beat_l[STAGES].pc;
    assign out_inst    = beat_l[STAGES].inst;
    assign out_rd_addr = beat_l[STAGES].rd_addr;
    assign out_data    = data_l[STAGES];

    for (genvar g = 0; g < STAGES; g++) begin : g_slot
        riscv_skid_slot #(.DATA_W(DATA_W)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (vld_l[g]),
            .in_ready  (rdy_l[g]),
            .in_beat   (beat_l[g]),
            .in_data   (data_l[g]),
            .out_valid (vld_l[g+1]),
            .out_ready (rdy_l[g+1]),
            .out_beat  (beat_l[g+1]),
            .out_data  (data_l[g+1]),
            .count     (cnt[g])
        );
    end

    // Occupancy is a pure sum of slot flops, so it is glitch-free of inputs
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) occupancy = occupancy + CNT_W'(cnt[i]);
    end

endmodule

// File: tb/tb_riscv_pipe_skid_stage.sv
// Scoreboard bench for riscv_pipe_skid_stage (STAGES=2, DATA_W=64).
module tb_riscv_pipe_skid_stage;

    localparam int DATA_W = 64;
    localparam int STAGES = 2;
    localparam int CNT_W  = $clog2(2*STAGES+1);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [63:0] data;
    } tb_beat_t;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0]       in_pc, out_pc;
    logic [31:0]       in_inst, out_inst;
    logic [4:0]        in_rd_addr, out_rd_addr;
    logic [DATA_W-1:0] in_data, out_data;
    logic [CNT_W-1:0]  occupancy;

    tb_beat_t exp_q[$];
    int       checks = 0;
    int       failures = 0;
    int       n_dlv = 0;
    logic     saw_aa = 1'b0;

    riscv_pipe_skid_stage #(.DATA_W(DATA_W), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_rd_addr(in_rd_addr), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_rd_addr(out_rd_addr), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic v, input logic [63:0] d);
        in_valid   = v;
        in_data    = d;
        in_pc      = 64'h8000_0000 + (d << 2);
        in_inst    = d[31:0] ^ 32'h0000_0013;
        in_rd_addr = d[4:0];
    endtask

    task automatic set_rand();
        in_valid   = ($urandom_range(0, 9) < 7);
        in_pc      = {$urandom, $urandom};
        in_inst    = $urandom;
        in_rd_addr = 5'($urandom);
        in_data    = {$urandom, $urandom};
    endtask

    // Monitor: sampled at negedge, describes the handshakes of the coming posedge.
    // Reference is a plain FIFO: pop on delivery, wipe on flush/reset, push on accept.
    always @(negedge clk) begin
        tb_beat_t e;
        if (rst) begin
            exp_q.delete();
        end else begin
            chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
            if (out_valid && out_ready) begin
                n_dlv++;
                if (out_data == 64'hAA) saw_aa = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual_data=%0h expected=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_inst", 64'(out_inst), 64'(e.inst));
                    chk("out_rd_addr", 64'(out_rd_addr), 64'(e.rd));
                    chk("out_data", out_data, e.data);
                end
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back('{in_pc, in_inst, in_rd_addr, in_data});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, n0, w, sent;
        logic [63:0] h_pc, h_data;
        logic [31:0] h_inst;

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_beat(1'b0, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk("rst_occupancy", 64'(occupancy), 64'h0);
        rst = 1'b0;
        #1 chk("release_cycle_in_ready", 64'(in_ready), 64'h0);
        tick();
        chk("post_release_in_ready", 64'(in_ready), 64'h1);

        // Unstalled stream: 2-cycle latency, one beat per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_beat(1'b1, 64'h10 + 64'(i));
            tick();
            chk("stream_in_ready", 64'(in_ready), 64'h1);
            if (i == 0) begin
                chk("stream_latency", 64'(out_valid), 64'h0);
            end else begin
                chk("stream_out_valid", 64'(out_valid), 64'h1);
                chk("stream_out_data", out_data, 64'h10 + 64'(i) - 64'h1);
                chk("stream_occupancy", 64'(occupancy), 64'h2);
            end
        end
        set_beat(1'b0, 64'h0);
        tick();
        chk("stream_last_data", out_data, 64'h17);
        tick();
        chk("stream_drained", 64'(out_valid), 64'h0);

        // Backpressure: capacity 4, then drain in order
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            set_beat(1'b1, 64'h20 + 64'(acc));
            if (in_ready) acc++;
            tick();
        end
        chk("bp_accepted", 64'(acc), 64'h4);
        chk("bp_in_ready", 64'(in_ready), 64'h0);
        chk("bp_occupancy", 64'(occupancy), 64'h4);
        set_beat(1'b0, 64'h0);
        out_ready = 1'b1;
        n0 = n_dlv;
        tick();
        tick();
        chk("bp_ready_back", 64'(in_ready), 64'h1);
        tick();
        tick();
        chk("bp_empty", 64'(out_valid), 64'h0);
        chk("bp_delivered", 64'(n_dlv - n0), 64'h4);

        // Output held stable under stall for 5 cycles, accepted on the 6th
        out_ready = 1'b0;
        set_beat(1'b1, 64'h30);
        tick();
        set_beat(1'b0, 64'h0);
        w = 0;
        while (!out_valid && w < 10) begin tick(); w++; end
        chk("hold_valid_seen", 64'(out_valid), 64'h1);
        h_pc = out_pc; h_inst = out_inst; h_data = out_data;
        for (int j = 1; j < 5; j++) begin
            tick();
            chk("hold_valid", 64'(out_valid), 64'h1);
            chk("hold_pc", out_pc, h_pc);
            chk("hold_inst", 64'(out_inst), 64'(h_inst));
            chk("hold_data", out_data, h_data);
        end
        out_ready = 1'b1;
        n0 = n_dlv;
        tick();
        chk("hold_accepted", 64'(n_dlv - n0), 64'h1);
        chk("hold_gone", 64'(out_valid), 64'h0);

        // Flush with occupancy 3 and a simultaneous push of 0xAA
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_beat(1'b1, 64'h40 + 64'(i));
            tick();
        end
        set_beat(1'b0, 64'h0);
        chk("flush_pre_occupancy", 64'(occupancy), 64'h3);
        saw_aa = 1'b0;
        flush = 1'b1;
        out_ready = 1'b1;
        set_beat(1'b1, 64'hAA);
        n0 = n_dlv;
        tick();
        flush = 1'b0;
        set_beat(1'b0, 64'h0);
        chk("flush_out_valid", 64'(out_valid), 64'h0);
        chk("flush_occupancy", 64'(occupancy), 64'h0);
        chk("flush_in_ready", 64'(in_ready), 64'h1);
        chk("flush_pop_delivered", 64'(n_dlv - n0), 64'h1);
        repeat (4) tick();
        chk("flush_no_aa", 64'(saw_aa), 64'h0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) begin
            set_beat(1'b1, 64'h50 + 64'(i));
            tick();
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'h0);
        chk("arst_in_ready", 64'(in_ready), 64'h0);
        chk("arst_occupancy", 64'(occupancy), 64'h0);
        set_beat(1'b0, 64'h0);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        chk("arst_no_output", 64'(out_valid), 64'h0);
        chk("arst_ready_back", 64'(in_ready), 64'h1);
        in_valid = 1'b1; in_pc = 64'hDEAD_BEEF_0000_1000; in_inst = 32'h00A5_0513;
        in_rd_addr = 5'd10; in_data = 64'h60;
        tick();
        set_beat(1'b0, 64'h0);
        w = 0;
        while (!out_valid && w < 5) begin tick(); w++; end
        chk("arst_first_valid", 64'(out_valid), 64'h1);
        chk("arst_first_pc", out_pc, 64'hDEAD_BEEF_0000_1000);
        chk("arst_first_inst", 64'(out_inst), 64'h00A5_0513);
        chk("arst_first_rd", 64'(out_rd_addr), 64'd10);
        repeat (3) tick();

        // Random traffic with 50% downstream stalls
        n0 = n_dlv;
        sent = 0;
        w = 0;
        while (sent < 1000 && w < 20000) begin
            set_rand();
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) sent++;
            tick();
            w++;
        end
        chk("rand_sent", 64'(sent), 64'd1000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin tick(); w++; end
        tick();
        chk("rand_drain_empty", 64'(exp_q.size()), 64'h0);
        chk("rand_delivered", 64'(n_dlv - n0), 64'd1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
